// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared bullet encodings, screen bounds and slot states
package tank_pkg;

    localparam int         BD_MOVE  = 2;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [7:0] MAX_X = 8'd159;
    localparam logic [6:0] MAX_Y = 7'd119;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LAUNCH,
        S_FLIGHT,
        S_KILL,
        S_COOLDOWN
    } slot_state_t;

    // True when the next step in direction dir would leave the screen.
    function automatic logic at_edge(input logic [1:0] dir, input logic [7:0] bx, input logic [6:0] by);
        case (dir)
            DIR_UP:   at_edge = (by == 7'd0);
            DIR_DOWN: at_edge = (by == MAX_Y);
            DIR_LEFT: at_edge = (bx == 8'd0);
            default:  at_edge = (bx == MAX_X);
        endcase
    endfunction

endpackage

// File: rtl/bullet_slot_fsm.sv
// rtl/bullet_slot_fsm.sv - per-player fire gating, flight tracking and cooldown
module bullet_slot_fsm
    import tank_pkg::*;
#(
    parameter int COOLDOWN_CYC = 25000000,
    parameter int CD_W         = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fire_key,
    input  logic        moving,
    input  logic        terminate,
    input  logic        force_idle,
    output logic        fire,
    output logic        ready,
    output slot_state_t state
);

    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYC - 1);

    slot_state_t     state_n;
    logic            key_prev;
    logic            key_rise;
    logic [CD_W-1:0] cnt;

    assign key_rise = fire_key & ~key_prev;

    // State register and key history; key_prev keeps a held key from re-firing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            key_prev <= 1'b0;
        end else begin
            state    <= state_n;
            key_prev <= fire_key;
        end
    end

    // Cooldown counter reads 0 in the first COOLDOWN cycle and counts up from there.
    always_ff @(posedge clk) begin
        if (reset || state != S_COOLDOWN) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state and outputs; force_idle recalls live bullets and parks the slot.
    always_comb begin
        state_n = state;
        fire    = 1'b0;
        ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !force_idle) state_n = S_ARMED;
            end
            S_ARMED: begin
                if (force_idle) begin
                    state_n = S_IDLE;
                end else if (key_rise) begin
                    state_n = S_LAUNCH;
                    fire    = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (force_idle)  state_n = S_KILL;
                else if (moving) state_n = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (force_idle || terminate) state_n = S_KILL;
            end
            S_KILL: begin
                ready = 1'b1;
                if (!moving) state_n = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (force_idle)           state_n = S_IDLE;
                else if (cnt == CD_LAST)  state_n = S_ARMED;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: rtl/bullet_ctrl.sv
// rtl/bullet_ctrl.sv - two-player bullet sequencer with hit detection and scoring
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int TANK_W       = 4,
    parameter int TANK_H       = 4,
    parameter int COOLDOWN_CYC = 25000000,
    parameter int CD_W         = 25,
    parameter int WIN_SCORE    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] fire_key,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    input  logic [6:0] ty0,
    input  logic [6:0] ty1,
    input  logic [7:0] bx0,
    input  logic [7:0] bx1,
    input  logic [6:0] by0,
    input  logic [6:0] by1,
    input  logic [2:0] bd0,
    input  logic [2:0] bd1,
    output logic [1:0] fire,
    output logic [1:0] ready,
    output logic [1:0] hit,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic       game_over,
    output logic [1:0] winner
);

    slot_state_t st0, st1;
    logic        flight0, flight1;
    logic        edge0, edge1;
    logic        in_box0, in_box1;
    logic        collide;
    logic        term0, term1;
    logic        score_ev0, score_ev1;
    logic [3:0]  sc0_n, sc1_n;
    logic        win0, win1;

    // Tank extents widened by one bit so tx+TANK_W-1 cannot wrap.
    logic [8:0] tx0_hi, tx1_hi;
    logic [7:0] ty0_hi, ty1_hi;

    assign tx0_hi = {1'b0, tx0} + 9'(TANK_W - 1);
    assign tx1_hi = {1'b0, tx1} + 9'(TANK_W - 1);
    assign ty0_hi = {1'b0, ty0} + 8'(TANK_H - 1);
    assign ty1_hi = {1'b0, ty1} + 8'(TANK_H - 1);

    assign flight0 = (st0 == S_FLIGHT);
    assign flight1 = (st1 == S_FLIGHT);

    assign edge0 = at_edge(bd0[1:0], bx0, by0);
    assign edge1 = at_edge(bd1[1:0], bx1, by1);

    // Each bullet is only ever tested against the opposing tank.
    assign in_box0 = ({1'b0, bx0} >= {1'b0, tx1}) && ({1'b0, bx0} <= tx1_hi) &&
                     ({1'b0, by0} >= {1'b0, ty1}) && ({1'b0, by0} <= ty1_hi);
    assign in_box1 = ({1'b0, bx1} >= {1'b0, tx0}) && ({1'b0, bx1} <= tx0_hi) &&
                     ({1'b0, by1} >= {1'b0, ty0}) && ({1'b0, by1} <= ty0_hi);

    assign collide = flight0 && flight1 && (bx0 == bx1) && (by0 == by1);

    assign term0 = flight0 && (collide || in_box0 || edge0);
    assign term1 = flight1 && (collide || in_box1 || edge1);

    // A collision cancels any hit in the same cycle; a hit on the edge still counts.
    assign score_ev0 = flight0 && in_box0 && !collide && !game_over;
    assign score_ev1 = flight1 && in_box1 && !collide && !game_over;
    assign hit       = {score_ev1, score_ev0};

    assign sc0_n = score0 + 4'(score_ev0);
    assign sc1_n = score1 + 4'(score_ev1);
    assign win0  = score_ev0 && (sc0_n >= 4'(WIN_SCORE));
    assign win1  = score_ev1 && (sc1_n >= 4'(WIN_SCORE));

    bullet_slot_fsm #(
        .COOLDOWN_CYC(COOLDOWN_CYC),
        .CD_W        (CD_W)
    ) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fire_key  (fire_key[0]),
        .moving    (bd0[BD_MOVE]),
        .terminate (term0),
        .force_idle(game_over),
        .fire      (fire[0]),
        .ready     (ready[0]),
        .state     (st0)
    );

    bullet_slot_fsm #(
        .COOLDOWN_CYC(COOLDOWN_CYC),
        .CD_W        (CD_W)
    ) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fire_key  (fire_key[1]),
        .moving    (bd1[BD_MOVE]),
        .terminate (term1),
        .force_idle(game_over),
        .fire      (fire[1]),
        .ready     (ready[1]),
        .state     (st1)
    );

    // Scores freeze once the game is decided; only reset clears the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            score0    <= 4'd0;
            score1    <= 4'd0;
            game_over <= 1'b0;
            winner    <= 2'b00;
        end else if (!game_over) begin
            score0 <= sc0_n;
            score1 <= sc1_n;
            if (win0 || win1) begin
                game_over <= 1'b1;
                winner    <= {win1, win0};
            end
        end
    end

endmodule
